// File: rtl/temp_display_formatter_if.sv
// LCD character-write bus between the temperature formatter and the LCD driver.
//   CharValid : character/address valid (formatter -> LCD)
//   CharReady : LCD accepts the character this cycle (LCD -> formatter)
//   CharData  : ASCII character code
//   CharAddr  : LCD column 0-31
interface temp_display_formatter_if;
    logic       CharValid;
    logic       CharReady;
    logic [7:0] CharData;
    logic [4:0] CharAddr;

    modport master (output CharValid, output CharData, output CharAddr, input CharReady);
    modport slave  (input CharValid, input CharData, input CharAddr, output CharReady);
endinterface

// File: rtl/temp_display_formatter.sv
// Takes an 8-bit temperature sample, runs it through the external binary-to-BCD
// converter and streams a five-character field (three digits, degree, unit) to
// the LCD character bus. Handles leading-zero blanking, '?' for non-decimal
// digits, '---' on converter timeout and a one-deep most-recent-wins buffer
// for samples arriving while busy.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   TempValid, TempBinary      new-sample strobe and value
//   ConvStart, ConvBinary      converter start pulse and operand
//   ConvDone, ConvHundreds/Tens/Ones   converter done level and BCD result
//   char_if (master)           CharValid/CharReady/CharData/CharAddr
//   Busy, FrameDone, Timeout   status: not idle, frame complete pulse, timeout pulse
module temp_display_formatter #(
    parameter int unsigned START_COL     = 0,
    parameter bit          LEADING_BLANK = 1'b1,
    parameter logic [7:0]  UNIT_CHAR     = 8'h43,
    parameter logic [7:0]  DEG_CHAR      = 8'hDF,
    parameter int unsigned CONV_TIMEOUT  = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       TempValid,
    input  logic [7:0] TempBinary,
    output logic       ConvStart,
    output logic [7:0] ConvBinary,
    input  logic       ConvDone,
    input  logic [3:0] ConvHundreds,
    input  logic [3:0] ConvTens,
    input  logic [3:0] ConvOnes,
    temp_display_formatter_if.master char_if,
    output logic       Busy,
    output logic       FrameDone,
    output logic       Timeout
);

    localparam logic [4:0] COL0 = 5'(START_COL);
    localparam logic [7:0] TMO  = 8'(CONV_TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT, SEND} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic [2:0] idx;
    logic [3:0] hun, ten, one;
    logic       inval;
    logic       pend;
    logic [7:0] pend_data;
    logic       hs, done_ok, tmo, last_hs;
    logic       blank_h, blank_t;
    logic [7:0] char_data;
    logic [4:0] char_addr;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    assign cnt_inc = cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done_ok  = 1'b0;
        tmo      = 1'b0;
        last_hs  = 1'b0;
        hs       = (state == SEND) && char_if.CharReady;
        case (state)
            IDLE:  if (TempValid) state_nx = START;
            START: state_nx = WAIT;
            WAIT: begin
                // done is still high from the previous conversion in the first
                // WAIT cycle, so it only counts once the counter has moved
                if (cnt != 8'd0 && ConvDone) begin
                    done_ok  = 1'b1;
                    state_nx = SEND;
                end else if (cnt_inc == TMO) begin
                    tmo      = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (hs && idx == 3'd4) begin
                    last_hs  = 1'b1;
                    state_nx = (pend || TempValid) ? START : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            hun        <= '0;
            ten        <= '0;
            one        <= '0;
            inval      <= 1'b0;
            pend       <= 1'b0;
            pend_data  <= '0;
            ConvBinary <= '0;
            FrameDone  <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            FrameDone <= last_hs;
            Timeout   <= tmo;
            case (state)
                IDLE:  if (TempValid) ConvBinary <= TempBinary;
                START: cnt <= '0;
                WAIT: begin
                    cnt <= cnt_inc;
                    if (done_ok) begin
                        hun   <= ConvHundreds;
                        ten   <= ConvTens;
                        one   <= ConvOnes;
                        inval <= 1'b0;
                        idx   <= '0;
                    end else if (tmo) begin
                        inval <= 1'b1;
                        idx   <= '0;
                    end
                end
                SEND: if (hs) idx <= last_hs ? 3'd0 : idx + 3'd1;
                default: ;
            endcase
            // A sample strobed on the closing handshake is newer than the
            // buffered one, so it is started directly.
            if (last_hs) begin
                pend <= 1'b0;
                if (TempValid)  ConvBinary <= TempBinary;
                else if (pend)  ConvBinary <= pend_data;
            end else if (TempValid && state != IDLE) begin
                pend      <= 1'b1;
                pend_data <= TempBinary;
            end
        end
    end

    always_comb begin
        blank_h   = LEADING_BLANK && !inval && (hun == 4'd0);
        blank_t   = blank_h && (ten == 4'd0);
        char_data = '0;
        char_addr = '0;
        if (state == SEND) begin
            char_addr = COL0 + {2'b00, idx};
            case (idx)
                3'd0:    char_data = inval ? 8'h2D : (blank_h ? 8'h20 : digit_char(hun));
                3'd1:    char_data = inval ? 8'h2D : (blank_t ? 8'h20 : digit_char(ten));
                3'd2:    char_data = inval ? 8'h2D : digit_char(one);
                3'd3:    char_data = DEG_CHAR;
                default: char_data = UNIT_CHAR;
            endcase
        end
    end

    assign ConvStart         = (state == START);
    assign Busy              = (state != IDLE);
    assign char_if.CharValid = (state == SEND);
    assign char_if.CharData  = char_data;
    assign char_if.CharAddr  = char_addr;

endmodule

// File: tb/tb_temp_display_formatter.sv
`timescale 1ns/1ps
module tb_temp_display_formatter;

    localparam logic [7:0] DEG   = 8'hDF;
    localparam logic [7:0] UNIT  = 8'h43;
    localparam int         COL_B = 30;
    localparam int         TMO_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       tv = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] tbin = '0;
    logic       rdy = 1'b0;
    logic       rdy_fixed = 1'b0;
    logic       rdy_rand = 1'b0;
    logic       cdone = 1'b0;
    logic [3:0] dg_h = '0, dg_t = '0, dg_o = '0;
    int         conv_delay = 4;
    bit         stale = 1'b0;
    bit         conv_ovr = 1'b0;
    int         ovr_h = 0, ovr_t = 0, ovr_o = 0;

    logic tv_a, tv_b;
    assign tv_a = tv & ~sel;
    assign tv_b = tv & sel;

    logic       cs_a, cs_b, busy_a, busy_b, fd_a, fd_b, to_a, to_b;
    logic [7:0] cbin_a, cbin_b;

    temp_display_formatter_if ifa ();
    temp_display_formatter_if ifb ();
    assign ifa.CharReady = rdy;
    assign ifb.CharReady = rdy;

    temp_display_formatter dut_a (
        .clk(clk), .rst_n(rst_n), .TempValid(tv_a), .TempBinary(tbin),
        .ConvStart(cs_a), .ConvBinary(cbin_a), .ConvDone(cdone),
        .ConvHundreds(dg_h), .ConvTens(dg_t), .ConvOnes(dg_o),
        .char_if(ifa), .Busy(busy_a), .FrameDone(fd_a), .Timeout(to_a)
    );

    temp_display_formatter #(
        .START_COL(COL_B), .LEADING_BLANK(1'b0), .CONV_TIMEOUT(TMO_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .TempValid(tv_b), .TempBinary(tbin),
        .ConvStart(cs_b), .ConvBinary(cbin_b), .ConvDone(cdone),
        .ConvHundreds(dg_h), .ConvTens(dg_t), .ConvOnes(dg_o),
        .char_if(ifb), .Busy(busy_b), .FrameDone(fd_b), .Timeout(to_b)
    );

    // outputs of the instance currently under test
    logic       o_cs, o_busy, o_fd, o_to, o_cv;
    logic [7:0] o_cbin, o_data;
    logic [4:0] o_addr;
    assign o_cs   = sel ? cs_b   : cs_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_fd   = sel ? fd_b   : fd_a;
    assign o_to   = sel ? to_b   : to_a;
    assign o_cbin = sel ? cbin_b : cbin_a;
    assign o_cv   = sel ? ifb.CharValid : ifa.CharValid;
    assign o_data = sel ? ifb.CharData  : ifa.CharData;
    assign o_addr = sel ? ifb.CharAddr  : ifa.CharAddr;

    int errors = 0;
    int checks = 0;

    // cycle counter
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // LCD ready generator
    initial forever begin
        @(posedge clk);
        #2;
        rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // converter: done (level) plus digits conv_delay cycles after the start pulse
    initial begin
        int  k;
        bit  act;
        k   = 0;
        act = 1'b0;
        forever begin
            @(negedge clk);
            if (o_cs) begin
                k   = 0;
                act = 1'b1;
                if (!stale) cdone = 1'b0;
            end else if (act) begin
                k++;
            end
            if (act) begin
                if (stale && k == 2) cdone = 1'b0;
                if (conv_delay != 0 && k == conv_delay) begin
                    if (conv_ovr) begin
                        dg_h = 4'(ovr_h); dg_t = 4'(ovr_t); dg_o = 4'(ovr_o);
                    end else begin
                        dg_h = 4'(o_cbin / 100);
                        dg_t = 4'((o_cbin / 10) % 10);
                        dg_o = 4'(o_cbin % 10);
                    end
                    cdone = 1'b1;
                    act   = 1'b0;
                end
            end
        end
    end

    // bus recorder
    logic [12:0] hs_q[$];
    int  stall_viol = 0, cs_cnt = 0, cs_wide = 0, fd_cnt = 0, to_cnt = 0;
    int  cs_cyc = 0, fd_cyc = 0, to_cyc = 0, first_cv_cyc = 0;
    logic busy_at_fd = 1'b0;
    initial begin
        bit         prev_stall, prev_cv, prev_cs;
        logic [7:0] pdata;
        logic [4:0] paddr;
        prev_stall = 0; prev_cv = 0; prev_cs = 0; pdata = '0; paddr = '0;
        forever begin
            @(negedge clk);
            if (o_cv && rdy) hs_q.push_back({o_addr, o_data});
            if (prev_stall && (!o_cv || o_data !== pdata || o_addr !== paddr)) stall_viol++;
            prev_stall = o_cv && !rdy && rst_n;
            pdata = o_data;
            paddr = o_addr;
            if (o_cv && !prev_cv) first_cv_cyc = cyc;
            prev_cv = o_cv;
            if (o_cs) begin
                cs_cnt++;
                cs_cyc = cyc;
                if (prev_cs) cs_wide++;
            end
            prev_cs = o_cs;
            if (o_fd) begin fd_cnt++; fd_cyc = cyc; busy_at_fd = o_busy; end
            if (o_to) begin to_cnt++; to_cyc = cyc; end
        end
    end

    int hs_rd = 0;

    // ---------------- reference model ----------------
    function automatic logic [39:0] frame_of_value(input int v, input bit blank);
        string s;
        s = blank ? $sformatf("%3d", v) : $sformatf("%03d", v);
        return {8'(s[0]), 8'(s[1]), 8'(s[2]), DEG, UNIT};
    endfunction

    function automatic logic [7:0] dchar(input int d);
        return (d > 9) ? 8'h3F : 8'(48 + d);
    endfunction

    function automatic logic [39:0] frame_of_digits(input int h, input int t, input int o, input bit blank);
        logic [7:0] c0, c1, c2;
        c0 = dchar(h); c1 = dchar(t); c2 = dchar(o);
        if (blank && h == 0) begin
            c0 = 8'h20;
            if (t == 0) c1 = 8'h20;
        end
        return {c0, c1, c2, DEG, UNIT};
    endfunction

    function automatic logic [24:0] addr_of(input int col);
        return {5'((col) % 32), 5'((col + 1) % 32), 5'((col + 2) % 32),
                5'((col + 3) % 32), 5'((col + 4) % 32)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v, output int c);
        tbin = v;
        tv   = 1'b1;
        c    = cyc;
        tick();
        tv   = 1'b0;
    endtask

    task automatic wait_fd(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (fd_cnt >= target) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic pop_frame(output logic [39:0] d, output logic [24:0] a, output bit ok);
        d = '0; a = '0; ok = 1'b0;
        if (hs_q.size() - hs_rd >= 5) begin
            for (int i = 0; i < 5; i++) begin
                d = {d[31:0], hs_q[hs_rd][7:0]};
                a = {a[19:0], hs_q[hs_rd][12:8]};
                hs_rd++;
            end
            ok = 1'b1;
        end
    endtask

    task automatic setup(input logic s, input logic rr, input logic rf, input int dly);
        sel = s; rdy_rand = rr; rdy_fixed = rf; conv_delay = dly;
        stale = 1'b0; conv_ovr = 1'b0;
        tick();
        hs_rd = hs_q.size();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; tv = 1'b0;
        repeat (3) tick();
        sel = 1'b0;
        #0;
        checks++;
        if ({o_cs, o_cbin, o_cv, o_data, o_addr, o_busy, o_fd, o_to} !== 27'd0) begin
            errors++;
            $display("FAIL reset_a got=%h want=0", {o_cs, o_cbin, o_cv, o_data, o_addr, o_busy, o_fd, o_to});
        end
        sel = 1'b1;
        #0;
        checks++;
        if ({o_cs, o_cbin, o_cv, o_data, o_addr, o_busy, o_fd, o_to} !== 27'd0) begin
            errors++;
            $display("FAIL reset_b got=%h want=0", {o_cs, o_cbin, o_cv, o_data, o_addr, o_busy, o_fd, o_to});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int c, fd0; bit ok, ok2; logic [39:0] d; logic [24:0] a;
        setup(1'b0, 1'b0, 1'b1, 10);
        fd0 = fd_cnt;
        send(8'd25, c);
        wait_fd(fd0 + 1, ok);
        repeat (5) tick();
        pop_frame(d, a, ok2);
        checks++;
        if (!ok2 || d !== frame_of_value(25, 1'b1)) begin
            errors++; $display("FAIL basic_chars got=%h want=%h", d, frame_of_value(25, 1'b1));
        end
        checks++;
        if (a !== addr_of(0)) begin errors++; $display("FAIL basic_addr got=%h want=%h", a, addr_of(0)); end
        checks++;
        if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL basic_fd_count got=%0d want=%0d", fd_cnt, fd0 + 1); end
        checks++;
        if (cs_cyc !== c + 1) begin errors++; $display("FAIL basic_start_cycle got=%0d want=%0d", cs_cyc, c + 1); end
        checks++;
        if (first_cv_cyc !== c + 12) begin errors++; $display("FAIL basic_first_cv got=%0d want=%0d", first_cv_cyc, c + 12); end
        checks++;
        if (fd_cyc !== c + 17) begin errors++; $display("FAIL basic_fd_cycle got=%0d want=%0d", fd_cyc, c + 17); end
        checks++;
        if (busy_at_fd !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy_low got=%b/%b want=0/0", busy_at_fd, o_busy);
        end
    endtask

    task automatic test_blank();
        int c, fd0; bit ok, ok2; logic [39:0] d; logic [24:0] a;
        setup(1'b0, 1'b0, 1'b1, 5);
        fd0 = fd_cnt;
        send(8'd7, c);
        wait_fd(fd0 + 1, ok);
        repeat (3) tick();
        pop_frame(d, a, ok2);
        checks++;
        if (!ok2 || d !== frame_of_value(7, 1'b1)) begin
            errors++; $display("FAIL blank_on got=%h want=%h", d, frame_of_value(7, 1'b1));
        end
        setup(1'b1, 1'b0, 1'b1, 6);
        fd0 = fd_cnt;
        send(8'd7, c);
        wait_fd(fd0 + 1, ok);
        repeat (3) tick();
        pop_frame(d, a, ok2);
        checks++;
        if (!ok2 || d !== frame_of_value(7, 1'b0)) begin
            errors++; $display("FAIL blank_off got=%h want=%h", d, frame_of_value(7, 1'b0));
        end
        checks++;
        if (a !== addr_of(COL_B)) begin errors++; $display("FAIL addr_wrap got=%h want=%h", a, addr_of(COL_B)); end
    endtask

    // converter done is still high (digits 0/0/7) from the previous frame
    task automatic test_stale_done();
        int c, fd0, cs0, w0; bit ok, ok2; logic [39:0] d; logic [24:0] a;
        setup(1'b0, 1'b0, 1'b1, 5);
        stale = 1'b1;
        fd0 = fd_cnt; cs0 = cs_cnt; w0 = cs_wide;
        send(8'd123, c);
        wait_fd(fd0 + 1, ok);
        repeat (3) tick();
        pop_frame(d, a, ok2);
        checks++;
        if (!ok2 || d !== frame_of_value(123, 1'b1)) begin
            errors++; $display("FAIL stale_chars got=%h want=%h", d, frame_of_value(123, 1'b1));
        end
        checks++;
        if (cs_cnt - cs0 !== 1 || cs_wide !== w0) begin
            errors++; $display("FAIL stale_start_width got=%0d/%0d want=1/0", cs_cnt - cs0, cs_wide - w0);
        end
        stale = 1'b0;
    endtask

    task automatic test_timeout();
        int c, fd0, to0; bit ok, ok2; logic [39:0] d; logic [24:0] a;
        setup(1'b1, 1'b0, 1'b1, 0);
        fd0 = fd_cnt; to0 = to_cnt;
        send(8'd88, c);
        wait_fd(fd0 + 1, ok);
        repeat (3) tick();
        pop_frame(d, a, ok2);
        checks++;
        if (!ok2 || d !== {8'h2D, 8'h2D, 8'h2D, DEG, UNIT}) begin
            errors++; $display("FAIL timeout_chars got=%h want=%h", d, {8'h2D, 8'h2D, 8'h2D, DEG, UNIT});
        end
        checks++;
        if (to_cnt - to0 !== 1) begin errors++; $display("FAIL timeout_count got=%0d want=1", to_cnt - to0); end
        checks++;
        if (to_cyc !== c + 2 + TMO_B) begin
            errors++; $display("FAIL timeout_cycle got=%0d want=%0d", to_cyc, c + 2 + TMO_B);
        end
        checks++;
        if (a !== addr_of(COL_B)) begin errors++; $display("FAIL timeout_addr got=%h want=%h", a, addr_of(COL_B)); end
        conv_delay = 4;
    endtask

    task automatic test_bad_digits();
        int c, fd0; bit ok, ok2; logic [39:0] d; logic [24:0] a;
        setup(1'b0, 1'b0, 1'b1, 3);
        conv_ovr = 1'b1; ovr_h = 0; ovr_t = 9; ovr_o = 10;
        fd0 = fd_cnt;
        send(8'd200, c);
        wait_fd(fd0 + 1, ok);
        repeat (3) tick();
        pop_frame(d, a, ok2);
        checks++;
        if (!ok2 || d !== frame_of_digits(0, 9, 10, 1'b1)) begin
            errors++; $display("FAIL bad_digits got=%h want=%h", d, frame_of_digits(0, 9, 10, 1'b1));
        end
        conv_ovr = 1'b0;
    endtask

    // sample queued while busy, then another strobed in the FrameDone cycle
    task automatic test_fd_pending();
        int c, fd0; bit ok, ok2; logic [39:0] d; logic [24:0] a;
        logic [7:0] vals [3];
        vals = '{8'd11, 8'd22, 8'd33};
        setup(1'b0, 1'b0, 1'b1, 3);
        fd0 = fd_cnt;
        send(vals[0], c);
        repeat (4) tick();
        send(vals[1], c);
        repeat (4) tick();
        checks++;
        if (o_fd !== 1'b1) begin errors++; $display("FAIL fdp_fd_cycle got=%b want=1", o_fd); end
        send(vals[2], c);
        wait_fd(fd0 + 3, ok);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            pop_frame(d, a, ok2);
            checks++;
            if (!ok2 || d !== frame_of_value(int'(vals[i]), 1'b1)) begin
                errors++; $display("FAIL fdp_frame%0d got=%h want=%h", i, d, frame_of_value(int'(vals[i]), 1'b1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int c, fd0, v0; bit ok, ok2; logic [39:0] d; logic [24:0] a;
        setup(1'b0, 1'b1, 1'b0, 4);
        fd0 = fd_cnt; v0 = stall_viol;
        send(8'd30, c);
        for (int i = 0; i < 100 && !o_cv; i++) tick();
        send(8'd40, c);
        send(8'd41, c);
        send(8'd42, c);
        wait_fd(fd0 + 2, ok);
        repeat (40) tick();
        checks++;
        if (fd_cnt - fd0 !== 2) begin errors++; $display("FAIL b2b_frames got=%0d want=2", fd_cnt - fd0); end
        pop_frame(d, a, ok2);
        checks++;
        if (!ok2 || d !== frame_of_value(30, 1'b1)) begin
            errors++; $display("FAIL b2b_first got=%h want=%h", d, frame_of_value(30, 1'b1));
        end
        pop_frame(d, a, ok2);
        checks++;
        if (!ok2 || d !== frame_of_value(42, 1'b1)) begin
            errors++; $display("FAIL b2b_latest got=%h want=%h", d, frame_of_value(42, 1'b1));
        end
        checks++;
        if (stall_viol !== v0) begin errors++; $display("FAIL b2b_stall_stable got=%0d want=%0d", stall_viol, v0); end
    endtask

    task automatic test_random();
        int c, fd0, v, v0; bit ok, ok2; logic [39:0] d; logic [24:0] a;
        setup(1'b0, 1'b1, 1'b0, 4);
        v0 = stall_viol;
        for (int n = 0; n < 16; n++) begin
            v = int'($urandom_range(0, 255));
            conv_delay = int'($urandom_range(2, 12));
            fd0 = fd_cnt;
            send(8'(v), c);
            wait_fd(fd0 + 1, ok);
            repeat (2) tick();
            pop_frame(d, a, ok2);
            checks++;
            if (!ok2 || {d, a} !== {frame_of_value(v, 1'b1), addr_of(0)}) begin
                errors++;
                $display("FAIL rand_frame v=%0d got=%h/%h want=%h/%h", v, d, a, frame_of_value(v, 1'b1), addr_of(0));
            end
        end
        checks++;
        if (stall_viol !== v0) begin errors++; $display("FAIL rand_stall_stable got=%0d want=%0d", stall_viol, v0); end
        rdy_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c, cs0, hs0;
        setup(1'b0, 1'b0, 1'b0, 3);
        send(8'd99, c);
        for (int i = 0; i < 100 && !o_cv; i++) tick();
        rdy_fixed = 1'b1;
        tbin = 8'd77; tv = 1'b1;
        tick();
        tv = 1'b0;
        tick();
        rdy_fixed = 1'b0;
        checks++;
        if (o_cv !== 1'b1 || o_addr !== 5'd2) begin
            errors++; $display("FAIL rstm_third_char got=%b/%0d want=1/2", o_cv, o_addr);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({o_cs, o_cbin, o_cv, o_data, o_addr, o_busy, o_fd, o_to} !== 27'd0) begin
            errors++;
            $display("FAIL rstm_outputs got=%h want=0", {o_cs, o_cbin, o_cv, o_data, o_addr, o_busy, o_fd, o_to});
        end
        rdy_fixed = 1'b1;
        cs0 = cs_cnt; hs0 = hs_q.size();
        repeat (40) tick();
        checks++;
        if (cs_cnt !== cs0 || hs_q.size() !== hs0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstm_pending_cleared got=%0d/%0d/%b want=0/0/0", cs_cnt - cs0, hs_q.size() - hs0, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank();
        test_stale_done();
        test_timeout();
        test_bad_digits();
        test_fd_pending();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
